fp_add_sequencer: RTL and testbench
===================================

// Module: fp_add_sequencer
// PURPOSE
//  Initiator side of the FloatAdder Start/Done byte-split interface. Accepts 16-bit half-float
//  operands as byte writes from the 8-bit processor datapath and holds them stable. On Go it
//  raises Start, captures the result on Done, then retires the handshake. Results are held with
//  a valid flag; a timeout error is flagged if the adder never answers. Sits between core and FPU.
// PARAMETERS
//  TIMEOUT_CYCLES  64       max cycles in RUN without Done before error (>=16)
//  ERR_PATTERN     16'h7E00 result loaded on timeout (half-float qNaN)
// PORTS
//  Clk            in   1  clock, all state on rising edge
//  Reset_n        in   1  asynchronous active-low reset
//  Wr_En          in   1  operand byte write strobe
//  Wr_Addr        in   2  0=A_MSB 1=A_LSB 2=B_MSB 3=B_LSB
//  Wr_Data        in   8  operand byte
//  Go             in   1  1-cycle request to start an addition
//  Busy           out  1  high in RUN/RELEASE
//  Result_Valid   out  1  result bytes valid; cleared by accepted Go
//  Error          out  1  timeout flag; cleared by accepted Go
//  Result_MSB     out  8  held result {sign,exp[4:0],mant[9:8]}
//  Result_LSB     out  8  held result mant[7:0]
//  Start          out  1  to adder: request, level
//  A_MSB_out/A_LSB_out/B_MSB_out/B_LSB_out  out 8 each  to adder: operand register contents
//  Result_MSB_in  in   8  from adder
//  Result_LSB_in  in   8  from adder
//  Done           in   1  from adder
// BEHAVIOUR
//  Reset (Reset_n=0, async, any state): state=IDLE; Start, Busy, Result_Valid, Error = 0;
//   all operand/result regs = 8'h00; timeout counter = 0. Start falls without waiting for a clock.
//  Operand regs: written on Wr_En when not Busy; Wr_En while Busy ignored. They drive *_out directly.
//  FSM IDLE -> RUN -> RELEASE -> IDLE:
//   IDLE: Go=1 -> RUN; clears Result_Valid, Error, and the counter. Done sampled in IDLE is ignored.
//    Wr_En and Go in the same cycle: the write lands first, so the new byte is used.
//   RUN: Start=1; counter increments each cycle.
//    First cycle Done=1 sampled: Result_MSB/LSB <= Result_*_in; -> RELEASE.
//    Capture is mandatory on that first Done cycle: the adder zeroes its result bytes one cycle later.
//    Counter reaches TIMEOUT_CYCLES with Done=0: Error<=1; Result <= ERR_PATTERN; -> RELEASE.
//    Done and timeout in the same cycle: Done wins, no error.
//   RELEASE: Start=0; stay until Done sampled 0, then -> IDLE.
//    Result_Valid<=1 on that transition; set after timeout too, with Error=1.
//  Go while Busy: ignored, not queued.
//  Latency with the 7-state adder: Go sampled at edge E0; Start high after E0; adder Done high after E7.
//   Capture at E8, Start low after E8; adder drops Done after E9; Result_Valid high after E10.
//  Result_Valid/Error/Result_* hold until the next accepted Go or reset.
//  Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.
// TESTING
//  1. Write A=16'h3C00, B=16'h3C00, pulse Go with the real adder ->
//     Busy 1 after E0, Start 1 for 8 cycles, Result_Valid 1 after E10, result = adder's Result_*_in at E8.
//  2. Model adder: Done high for 1 cycle at E5 with result 8'hAB/8'hCD, zero after ->
//     Result_MSB=AB, Result_LSB=CD; Error=0.
//  3. Done tied 0 -> after TIMEOUT_CYCLES RUN cycles: Error=1, Result=7E00, Start=0, Result_Valid=1.
//  4. Wr_En addr0 data 8'h55 while Busy -> A_MSB_out unchanged.
//     Go while Busy -> no second Start pulse.
//  5. Reset_n low mid-RUN -> Start/Busy/Result_Valid = 0 immediately.
//     Go after release -> normal completion as test 1.
//  6. Wr_En addr3 data 8'h12 and Go in the same cycle -> B_LSB_out=12 when the adder samples; stale Done in IDLE ignored.

Source files
------------

// File: rtl/fp_add_sequencer.sv
// Initiator for the FloatAdder Start/Done byte-split handshake: holds operands, runs one add per Go.
// Latency: Go at E0 -> Start after E0; capture on first Done cycle; Result_Valid one cycle after Done drops.
// Backpressure: Go and operand writes are dropped while Busy; no queueing, adder paced by Done.
//
// Ports:
//   Clk, Reset_n                         clock (rising edge), async active-low reset
//   Wr_En, Wr_Addr, Wr_Data              operand byte writes (0=A_MSB 1=A_LSB 2=B_MSB 3=B_LSB)
//   Go                                   one-cycle request to start an addition
//   Busy, Result_Valid, Error            status to core
//   Result_MSB, Result_LSB               held result bytes
//   Start, A/B_*_out                     request and operands to the adder
//   Result_MSB_in, Result_LSB_in, Done   response from the adder
module fp_add_sequencer #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] ERR_PATTERN    = 16'h7E00
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Wr_En,
    input  logic [1:0] Wr_Addr,
    input  logic [7:0] Wr_Data,
    input  logic       Go,
    output logic       Busy,
    output logic       Result_Valid,
    output logic       Error,
    output logic [7:0] Result_MSB,
    output logic [7:0] Result_LSB,
    output logic       Start,
    output logic [7:0] A_MSB_out,
    output logic [7:0] A_LSB_out,
    output logic [7:0] B_MSB_out,
    output logic [7:0] B_LSB_out,
    input  logic [7:0] Result_MSB_in,
    input  logic [7:0] Result_LSB_in,
    input  logic       Done
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] run_cnt;

    // Operand registers feed the adder directly; frozen while a transaction is in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            A_MSB_out <= 8'h00;
            A_LSB_out <= 8'h00;
            B_MSB_out <= 8'h00;
            B_LSB_out <= 8'h00;
        end else if (Wr_En && !Busy) begin
            case (Wr_Addr)
                2'd0: A_MSB_out <= Wr_Data;
                2'd1: A_LSB_out <= Wr_Data;
                2'd2: B_MSB_out <= Wr_Data;
                2'd3: B_LSB_out <= Wr_Data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            run_cnt      <= '0;
            Start        <= 1'b0;
            Busy         <= 1'b0;
            Result_Valid <= 1'b0;
            Error        <= 1'b0;
            Result_MSB   <= 8'h00;
            Result_LSB   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    // Done seen here is stale from a previous transaction and is ignored.
                    if (Go) begin
                        state        <= S_RUN;
                        Start        <= 1'b1;
                        Busy         <= 1'b1;
                        Result_Valid <= 1'b0;
                        Error        <= 1'b0;
                        run_cnt      <= '0;
                    end
                end
                S_RUN: begin
                    if (run_cnt != CNT_MAX) begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                    // The adder clears its result bytes one cycle after raising Done,
                    // so this first Done cycle is the only chance to capture.
                    if (Done) begin
                        Result_MSB <= Result_MSB_in;
                        Result_LSB <= Result_LSB_in;
                        Start      <= 1'b0;
                        state      <= S_RELEASE;
                    end else if (run_cnt >= CNT_LAST) begin
                        // This edge completes TIMEOUT_CYCLES RUN cycles without an answer.
                        Error      <= 1'b1;
                        Result_MSB <= ERR_PATTERN[15:8];
                        Result_LSB <= ERR_PATTERN[7:0];
                        Start      <= 1'b0;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // Wait for the adder to retire Done before allowing another request.
                    if (!Done) begin
                        state        <= S_IDLE;
                        Busy         <= 1'b0;
                        Result_Valid <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    Start <= 1'b0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a behavioural adder partner and a result scoreboard.
// Latency: checks Start width, capture edge and Result_Valid edge against the handshake timing.
// Backpressure: exercises writes/Go while Busy, timeout, mid-run reset and stale Done in IDLE.
module tb_fp_add_sequencer;

    localparam int TIMEOUT = 64;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Wr_En = 1'b0;
    logic [1:0] Wr_Addr = 2'd0;
    logic [7:0] Wr_Data = 8'h00;
    logic       Go = 1'b0;
    logic       Busy, Result_Valid, Error, Start;
    logic [7:0] Result_MSB, Result_LSB;
    logic [7:0] A_MSB_out, A_LSB_out, B_MSB_out, B_LSB_out;
    logic [7:0] Result_MSB_in, Result_LSB_in;
    logic       Done;

    fp_add_sequencer #(.TIMEOUT_CYCLES(TIMEOUT), .ERR_PATTERN(16'h7E00)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Wr_En(Wr_En), .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Go(Go),
        .Busy(Busy), .Result_Valid(Result_Valid), .Error(Error),
        .Result_MSB(Result_MSB), .Result_LSB(Result_LSB),
        .Start(Start),
        .A_MSB_out(A_MSB_out), .A_LSB_out(A_LSB_out),
        .B_MSB_out(B_MSB_out), .B_LSB_out(B_LSB_out),
        .Result_MSB_in(Result_MSB_in), .Result_LSB_in(Result_LSB_in),
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    // ---------------- adder partner model ----------------
    // MODE_SEVEN: Done rises after the 7th edge of Start, result zeroed one cycle later,
    //             Done held until Start drops.
    // MODE_FAST : Done pulses for one cycle (captured at E5) with 16'hABCD, zero after.
    // MODE_DEAD : never answers.
    localparam int MODE_SEVEN = 0, MODE_FAST = 1, MODE_DEAD = 2;
    int          mode = MODE_SEVEN;
    int          acnt = 0;
    logic        fired = 1'b0;
    logic        done_m = 1'b0;
    logic        force_done = 1'b0;
    logic [15:0] res_m = 16'h0000;

    // Stand-in arithmetic: equal operands double (exponent + 1), otherwise XOR.
    function automatic logic [15:0] add_model(input logic [15:0] a, input logic [15:0] b);
        return (a == b) ? a + 16'h0400 : a ^ b;
    endfunction

    assign Done          = done_m | force_done;
    assign Result_MSB_in = res_m[15:8];
    assign Result_LSB_in = res_m[7:0];

    always @(posedge Clk) begin
        if (!Start) begin
            acnt   <= 0;
            fired  <= 1'b0;
            done_m <= 1'b0;
        end else if (done_m) begin
            res_m <= 16'h0000;
            if (mode == MODE_FAST) done_m <= 1'b0;
        end else if (!fired && mode != MODE_DEAD) begin
            if (acnt == ((mode == MODE_FAST) ? 3 : 6)) begin
                done_m <= 1'b1;
                fired  <= 1'b1;
                res_m  <= (mode == MODE_FAST) ? 16'hABCD :
                          add_model({A_MSB_out, A_LSB_out}, {B_MSB_out, B_LSB_out});
            end else begin
                acnt <= acnt + 1;
            end
        end
    end

    // Start rising-edge counter, sampled mid-cycle.
    int   start_rises = 0;
    logic start_q = 1'b0;
    always @(negedge Clk) begin
        if (Start && !start_q) start_rises++;
        start_q = Start;
    end

    // ---------------- scoreboard / checking ----------------
    logic [15:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_op(input logic [1:0] addr, input logic [7:0] data);
        Wr_En = 1'b1; Wr_Addr = addr; Wr_Data = data;
        tick();
        Wr_En = 1'b0;
    endtask

    task automatic pulse_go();
        Go = 1'b1;
        tick();
        Go = 1'b0;
    endtask

    task automatic pop_compare(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, {Result_MSB, Result_LSB});
        end else begin
            e = exp_q.pop_front();
            check(tag, {16'h0, Result_MSB, Result_LSB}, {16'h0, e});
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!Result_Valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(Result_Valid), 32'd1);
        if (Result_Valid) pop_compare({tag, "_result"});
    endtask

    task automatic load_operands(input logic [15:0] a, input logic [15:0] b);
        write_op(2'd0, a[15:8]);
        write_op(2'd1, a[7:0]);
        write_op(2'd2, b[15:8]);
        write_op(2'd3, b[7:0]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rises0;

        // ---- reset state ----
        #2;
        check("rst_start", 32'(Start), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_valid_err", {30'd0, Result_Valid, Error}, 32'd0);
        check("rst_result", {16'h0, Result_MSB, Result_LSB}, 32'h0);
        check("rst_operands", {A_MSB_out, A_LSB_out, B_MSB_out, B_LSB_out}, 32'h0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // ---- test 1: 1.0 + 1.0 with the seven-state adder, exact latency ----
        mode = MODE_SEVEN;
        load_operands(16'h3C00, 16'h3C00);
        check("t1_operands", {A_MSB_out, A_LSB_out, B_MSB_out, B_LSB_out}, 32'h3C003C00);
        exp_q.push_back(add_model(16'h3C00, 16'h3C00));
        pulse_go();                                   // E0
        check("t1_busy_after_e0", 32'(Busy), 32'd1);
        n = 0;
        while (Start && n < 100) begin n++; tick(); end
        check("t1_start_width", 32'(n), 32'd8);       // now after E8
        check("t1_busy_release", 32'(Busy), 32'd1);
        tick();                                       // E9
        check("t1_valid_e9", 32'(Result_Valid), 32'd0);
        tick();                                       // E10
        check("t1_valid_e10", 32'(Result_Valid), 32'd1);
        pop_compare("t1_result");
        check("t1_error", 32'(Error), 32'd0);
        check("t1_busy_done", 32'(Busy), 32'd0);

        // ---- test 4: write and Go while Busy are ignored ----
        rises0 = start_rises;
        exp_q.push_back(add_model(16'h3C00, 16'h3C00));
        pulse_go();
        check("t4_valid_cleared", 32'(Result_Valid), 32'd0);
        write_op(2'd0, 8'h55);
        check("t4_a_msb_frozen", 32'(A_MSB_out), 32'h3C);
        pulse_go();
        wait_valid("t4", 40);
        repeat (6) tick();
        check("t4_single_start", 32'(start_rises - rises0), 32'd1);
        check("t4_idle", {30'd0, Busy, Start}, 32'd0);

        // ---- test 2: fast one-cycle Done with AB/CD ----
        mode = MODE_FAST;
        exp_q.push_back(16'hABCD);
        pulse_go();
        wait_valid("t2", 40);
        check("t2_error", 32'(Error), 32'd0);

        // ---- test 3: adder never answers ----
        mode = MODE_DEAD;
        exp_q.push_back(16'h7E00);
        pulse_go();
        n = 0;
        while (Start && n < 200) begin n++; tick(); end
        check("t3_start_width", 32'(n), 32'(TIMEOUT));
        wait_valid("t3", 10);
        check("t3_error", 32'(Error), 32'd1);
        check("t3_start_low", 32'(Start), 32'd0);

        // ---- test 5: reset mid-RUN, then normal completion ----
        mode = MODE_SEVEN;
        pulse_go();
        check("t5_error_cleared", 32'(Error), 32'd0);
        tick(); tick();
        Reset_n = 1'b0;
        #1;
        check("t5_rst_start_busy", {30'd0, Start, Busy}, 32'd0);
        check("t5_rst_valid", 32'(Result_Valid), 32'd0);
        check("t5_rst_operands", {A_MSB_out, A_LSB_out, B_MSB_out, B_LSB_out}, 32'h0);
        exp_q.delete();
        tick();
        Reset_n = 1'b1;
        tick(); tick();
        load_operands(16'h3C00, 16'h3C00);
        exp_q.push_back(add_model(16'h3C00, 16'h3C00));
        pulse_go();
        wait_valid("t5", 40);

        // ---- test 6: stale Done in IDLE, then write + Go in the same cycle ----
        force_done = 1'b1;
        tick(); tick();
        force_done = 1'b0;
        check("t6_stale_busy", 32'(Busy), 32'd0);
        check("t6_stale_valid", 32'(Result_Valid), 32'd1);
        check("t6_stale_result", {16'h0, Result_MSB, Result_LSB}, 32'h4000);
        tick();
        exp_q.push_back(add_model(16'h3C00, 16'h3C12));
        Wr_En = 1'b1; Wr_Addr = 2'd3; Wr_Data = 8'h12; Go = 1'b1;
        tick();
        Wr_En = 1'b0; Go = 1'b0;
        check("t6_b_lsb", 32'(B_LSB_out), 32'h12);
        check("t6_start", 32'(Start), 32'd1);
        wait_valid("t6", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
